// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetches one instruction word at a time, holds it until consumed, then advances pc
// Ports:
//   clk, reset (async, active-low)
//   imem_req/imem_addr -> memory request; imem_rdata/imem_ready <- memory response
//   stall           : hold the current instruction
//   branch_eq/ne,zero: branch decision inputs for the held instruction
//   instr/opcode/instr_valid : held instruction and its valid flag
//   pc/pc_plus4     : held or current fetch address and its successor
//   instr_count     : number of consumed instructions
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        branch_eq,
    input  logic        branch_ne,
    input  logic        zero,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr_count
);
    typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;
    state_t      state_q;
    logic [31:0] pc_q, instr_q, count_q, target, pc_d;
    logic        valid_q, req_q, taken;
    assign pc_plus4    = pc_q + 32'd4;
    // word offset sign-extended and scaled to bytes; keeps the address word-aligned
    assign target      = pc_plus4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign taken       = (branch_eq & zero) | (branch_ne & ~zero);
    assign pc_d        = taken ? target : pc_plus4;
    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign instr_count = count_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
            req_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= FETCH;
                    req_q   <= 1'b1;
                end
                FETCH: if (imem_ready) begin
                    instr_q <= imem_rdata;
                    valid_q <= 1'b1;
                    req_q   <= 1'b0;
                    state_q <= VALID;
                end
                VALID: if (!stall) begin
                    pc_q    <= pc_d;
                    valid_q <= 1'b0;
                    count_q <= count_q + 32'd1;
                    req_q   <= 1'b1;
                    state_q <= FETCH;
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed stimulus with a behavioural model checked every cycle
module tb_instruction_fetch_unit;
    localparam logic [31:0] BASE  = 32'h0040_0000;
    localparam logic [31:0] BASE2 = 32'hFFFF_FFFC;
    localparam logic [31:0] DELTA = BASE2 - BASE;
    logic        clk = 1'b0, reset = 1'b1;
    logic [31:0] imem_rdata = '0;
    logic        imem_ready = 1'b0, stall = 1'b0, branch_eq = 1'b0, branch_ne = 1'b0, zero = 1'b0;
    logic        imem_req, instr_valid, req2, valid2;
    logic [31:0] imem_addr, instr, pc, pc_plus4, instr_count;
    logic [31:0] addr2, instr2, pc2, pc4_2, count2;
    logic [5:0]  opcode, opcode2;
    int          checks = 0, failures = 0;
    // model: fresh = first edge after reset, have = instruction held
    logic        m_fresh = 1'b1, m_have = 1'b0;
    logic [31:0] m_pc = BASE, m_instr = '0, m_cnt = '0;

    instruction_fetch_unit #(.RESET_PC(BASE)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready), .stall(stall),
        .branch_eq(branch_eq), .branch_ne(branch_ne), .zero(zero), .instr(instr),
        .opcode(opcode), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
        .instr_count(instr_count));

    instruction_fetch_unit #(.RESET_PC(BASE2)) dut2 (
        .clk(clk), .reset(reset), .imem_req(req2), .imem_addr(addr2),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready), .stall(stall),
        .branch_eq(branch_eq), .branch_ne(branch_ne), .zero(zero), .instr(instr2),
        .opcode(opcode2), .instr_valid(valid2), .pc(pc2), .pc_plus4(pc4_2),
        .instr_count(count2));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_fresh = 1'b1;
            m_have  = 1'b0;
            m_pc    = BASE;
            m_instr = '0;
            m_cnt   = '0;
        end else if (m_fresh) begin
            m_fresh = 1'b0;
        end else if (!m_have) begin
            if (imem_ready) begin
                m_have  = 1'b1;
                m_instr = imem_rdata;
            end
        end else if (!stall) begin
            m_pc = m_pc + 32'd4 +
                   (((branch_eq && zero) || (branch_ne && !zero)) ? 32'($signed(m_instr[15:0])) * 32'd4 : 32'd0);
            m_have = 1'b0;
            m_cnt  = m_cnt + 32'd1;
        end
    end

    always @(negedge clk) begin
        chk("req", 32'(imem_req), 32'(reset && !m_fresh && !m_have));
        chk("addr", imem_addr, m_pc);
        chk("pc", pc, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("instr", instr, m_instr);
        chk("opcode", 32'(opcode), 32'(m_instr[31:26]));
        chk("valid", 32'(instr_valid), 32'(m_have));
        chk("count", instr_count, m_cnt);
        chk("pc2", pc2, m_pc + DELTA);
        chk("addr2", addr2, m_pc + DELTA);
        chk("pc4_2", pc4_2, m_pc + DELTA + 32'd4);
        chk("req2", 32'(req2), 32'(reset && !m_fresh && !m_have));
        chk("instr2", instr2, m_instr);
        chk("opcode2", 32'(opcode2), 32'(m_instr[31:26]));
        chk("valid2", 32'(valid2), 32'(m_have));
        chk("count2", count2, m_cnt);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 reset = 1'b0;
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_pc", pc, BASE);
        chk("rst_pc2", pc2, BASE2);
        chk("rst_count", instr_count, 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        step();
        step();
        reset = 1'b1;
        step();
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, 32'h0040_0000);
        imem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            imem_rdata = 32'h2001_0000 | 32'(k);
            step();
            chk("seq_valid", 32'(instr_valid), 32'd1);
            chk("seq_instr", instr, 32'h2001_0000 | 32'(k));
            chk("seq_opcode", 32'(opcode), 32'h08);
            step();
            chk("seq_valid_lo", 32'(instr_valid), 32'd0);
            chk("seq_count", instr_count, 32'(k + 1));
            chk("seq_addr", imem_addr, 32'h0040_0004 + 32'(4 * k));
            if (k == 0) chk("wrap_addr2", addr2, 32'h0000_0000);
        end
        imem_ready = 1'b0;
        repeat (3) begin
            step();
            chk("wait_req", 32'(imem_req), 32'd1);
            chk("wait_addr", imem_addr, 32'h0040_000C);
            chk("wait_valid", 32'(instr_valid), 32'd0);
        end
        imem_rdata = 32'h8C22_0004;
        imem_ready = 1'b1;
        step();
        chk("late_valid", 32'(instr_valid), 32'd1);
        chk("late_instr", instr, 32'h8C22_0004);
        chk("late_opcode", 32'(opcode), 32'h23);
        imem_ready = 1'b0;
        step();
        chk("late_pc", pc, 32'h0040_0010);
        imem_rdata = 32'h1000_FFFE;
        imem_ready = 1'b1;
        branch_eq = 1'b1;
        zero = 1'b1;
        step();
        imem_ready = 1'b0;
        step();
        chk("beq_taken", imem_addr, 32'h0040_000C);
        branch_eq = 1'b0;
        imem_rdata = 32'h2001_0000;
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        step();
        chk("back_addr", imem_addr, 32'h0040_0010);
        imem_rdata = 32'h1000_FFFE;
        imem_ready = 1'b1;
        branch_eq = 1'b1;
        zero = 1'b0;
        step();
        imem_ready = 1'b0;
        step();
        chk("beq_not", imem_addr, 32'h0040_0014);
        chk("beq_count", instr_count, 32'd7);
        imem_rdata = 32'h1400_0003;
        imem_ready = 1'b1;
        branch_eq = 1'b0;
        branch_ne = 1'b1;
        zero = 1'b1;
        stall = 1'b1;
        step();
        imem_ready = 1'b0;
        zero = 1'b0;
        repeat (4) begin
            step();
            chk("stall_pc", pc, 32'h0040_0014);
            chk("stall_instr", instr, 32'h1400_0003);
            chk("stall_count", instr_count, 32'd7);
            chk("stall_valid", 32'(instr_valid), 32'd1);
        end
        stall = 1'b0;
        zero = 1'b1;
        step();
        chk("bne_not", imem_addr, 32'h0040_0018);
        chk("bne_count", instr_count, 32'd8);
        imem_rdata = 32'h1000_0004;
        imem_ready = 1'b1;
        branch_eq = 1'b1;
        branch_ne = 1'b1;
        zero = 1'b0;
        step();
        imem_ready = 1'b0;
        step();
        chk("both_taken", imem_addr, 32'h0040_002C);
        branch_eq = 1'b0;
        branch_ne = 1'b0;
        #2 reset = 1'b0;
        imem_ready = 1'b1;
        #1;
        chk("async_req", 32'(imem_req), 32'd0);
        chk("async_pc", pc, BASE);
        chk("async_instr", instr, 32'd0);
        chk("async_valid", 32'(instr_valid), 32'd0);
        chk("async_count", instr_count, 32'd0);
        step();
        step();
        chk("held_valid", 32'(instr_valid), 32'd0);
        reset = 1'b1;
        imem_rdata = 32'h2002_0007;
        step();
        chk("rel_req", 32'(imem_req), 32'd1);
        chk("rel_addr", imem_addr, 32'h0040_0000);
        chk("rel_valid", 32'(instr_valid), 32'd0);
        step();
        chk("rel_instr", instr, 32'h2002_0007);
        step();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
